bram_sdp_arbiter: RTL and testbench
===================================

BRAM_SDP_ARBITER -- requirements
Module: bram_sdp_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one simple-dual-port RAM.
REQ-002 SHALL have parameter SIZE, default 512, RAM depth in words.
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, RAM address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-005 SHALL use one clock and a reset that is synchronous and active-high.
REQ-006 clk  in  1  single clock for all logic and both RAM ports.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 req_valid  in  N_REQ  per-requester request pending.
REQ-009 req_we  in  N_REQ  per-requester 1 = write, 0 = read.
REQ-010 req_addr  in  N_REQ x ADDR_WIDTH  per-requester word address.
REQ-011 req_wdata  in  N_REQ x DATA_WIDTH  per-requester write data.
REQ-012 req_ready  out  N_REQ  per-requester grant; a transfer occurs when valid and ready are both high.
REQ-013 rsp_valid  out  N_REQ  one-hot read response strobe.
REQ-014 rsp_rdata  out  DATA_WIDTH  read data, valid only while any rsp_valid bit is high.
REQ-015 busy  out  1  high while the clear sequence runs.
REQ-016 mem_ena, mem_wea, mem_addra, mem_dia  out  1/1/ADDR_WIDTH/DATA_WIDTH  RAM write port.
REQ-017 mem_enb, mem_addrb  out  1/ADDR_WIDTH  RAM read port.
REQ-018 mem_dob  in  DATA_WIDTH  RAM registered read data, 1-cycle latency.

Function
REQ-019 SHALL implement the states CLEAR and RUN; reset enters CLEAR with the clear counter at 0.
REQ-020 CLEAR: SHALL write 0 to address = counter every cycle, with mem_ena=mem_wea=1 and mem_enb=0; req_ready=0; busy=1.
REQ-021 CLEAR: SHALL go to RUN on the cycle after the write to SIZE-1; the counter SHALL stop at SIZE-1, with no wrap and no extra write.
REQ-022 RUN: busy=0; the write and read arbiters SHALL operate independently in the same cycle.
REQ-023 The write arbiter SHALL choose among i with req_valid[i]&req_we[i], round-robin from pointer wptr; on grant, wptr SHALL become grant+1 mod N_REQ.
REQ-024 The read arbiter SHALL choose among i with req_valid[i]&!req_we[i], round-robin from pointer rptr; it SHALL update the same way.
REQ-025 req_ready SHALL be combinational: at most one write grant and one read grant per cycle, and never both to the same requester.
REQ-026 A write grant SHALL drive mem_ena=mem_wea=1, mem_addra=req_addr[g] and mem_dia=req_wdata[g] in the same cycle.
REQ-027 A read grant SHALL drive mem_enb=1 and mem_addrb=req_addr[g]; rsp_valid[g] SHALL be 1 exactly one cycle later, with rsp_rdata = mem_dob passed through.
REQ-028 With no grant, the port enables SHALL be 0 and the pointers SHALL hold.
REQ-029 Same-address read and write in one cycle: the read SHALL return the old data; a read one cycle after a write SHALL return the new data.
REQ-030 Read throughput SHALL be one grant per cycle, back-to-back, with no bubbles.

Reset
REQ-031 On reset: state=CLEAR, counter=0, wptr=rptr=0, rsp_valid=0, req_ready=0, busy=1.
REQ-032 Reset during CLEAR SHALL restart the clear at address 0.
REQ-033 Reset during RUN SHALL drop any pending read response, so rsp_valid=0 in the next cycle.

Structure
REQ-034 The state enum and the default N_REQ, ADDR_WIDTH and DATA_WIDTH constants SHALL reside in riscv_pkg.
REQ-035 Round-robin grant logic SHALL be one sub-module, rr_arbiter (parameter N, inputs req and ptr, output one-hot grant), instantiated twice.
REQ-036 The RAM SHALL sit outside the block and connect to the existing BRAM_SDP through the mem_* ports.

Verification
REQ-037 Release reset -> busy=1 for exactly 512 cycles, addresses 0..511 written with 0, then busy=0; during that time req_valid=1111 -> req_ready=0000.
REQ-038 After clear, requesters 0-3 all read with wptr/rptr=0 -> grants 0,1,2,3,0 on consecutive cycles; each rsp_valid one cycle after its grant.
REQ-039 Requester 1 writes 0xDEADBEEF to address 5 while requester 2 reads address 5 in the same cycle -> requester 2 gets 0; a read of address 5 on the next cycle -> 0xDEADBEEF.
REQ-040 Requester 0 writes and requester 3 reads in the same cycle -> both ready=1; mem_ena and mem_enb both 1.
REQ-041 Assert reset at clear counter 200 -> clearing restarts at address 0 and busy stays high for 512 more cycles.
REQ-042 Assert reset the cycle after a read grant -> no rsp_valid pulse appears.

Source files
------------

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared types and default sizing for the BRAM simple-dual-port arbiter.
//   Contents:
//     DEF_*        default requester count, RAM depth and RAM widths
//     arb_state_e  arbiter state (CLEAR after reset, RUN once the RAM is zeroed)
//     rr_next      round-robin pointer advance: grant index + 1, modulo n
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int DEF_N_REQ      = 4;
   localparam int DEF_SIZE       = 512;
   localparam int DEF_ADDR_WIDTH = 9;
   localparam int DEF_DATA_WIDTH = 32;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } arb_state_e;

   function automatic int unsigned rr_next(input int unsigned grant_idx,
                                           input int unsigned n);
      return (grant_idx + 1 >= n) ? 0 : grant_idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker. Starting at index ptr and wrapping
//   through N, the first asserted req bit wins.
//   Ports:
//     req    in  N      request vector
//     ptr    in  PTR_W  index with the highest priority this cycle
//     grant  out N      one-hot grant (all zero when req is zero)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant
);

   int   idx;
   logic found;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can
      // leave it unassigned and infer a latch.
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bram_sdp_arbiter.sv
// -----------------------------------------------------------------------------
// bram_sdp_arbiter
//   Shares one external simple-dual-port RAM between N_REQ requesters. After
//   reset the whole RAM is zeroed (CLEAR); then independent round-robin write
//   and read arbiters grant at most one write and one read per cycle (RUN).
//   Ports:
//     clk, reset        clock; synchronous active-high reset
//     req_valid/we      per-requester request and direction (1 = write)
//     req_addr/wdata    per-requester word address and write data
//     req_ready         per-requester combinational grant
//     rsp_valid         one-hot read response, one cycle after the read grant
//     rsp_rdata         RAM read data passed through
//     busy              high while the RAM is being cleared
//     mem_ena/wea/addra/dia   RAM write port
//     mem_enb/addrb/dob       RAM read port (dob has 1-cycle latency)
// -----------------------------------------------------------------------------
module bram_sdp_arbiter
   import riscv_pkg::*;
#(
   parameter int N_REQ      = DEF_N_REQ,
   parameter int SIZE       = DEF_SIZE,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [N_REQ-1:0]                     req_valid,
   input  logic [N_REQ-1:0]                     req_we,
   input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     req_addr,
   input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_wdata,
   output logic [N_REQ-1:0]                     req_ready,
   output logic [N_REQ-1:0]                     rsp_valid,
   output logic [DATA_WIDTH-1:0]                rsp_rdata,
   output logic                                 busy,
   output logic                                 mem_ena,
   output logic                                 mem_wea,
   output logic [ADDR_WIDTH-1:0]                mem_addra,
   output logic [DATA_WIDTH-1:0]                mem_dia,
   output logic                                 mem_enb,
   output logic [ADDR_WIDTH-1:0]                mem_addrb,
   input  logic [DATA_WIDTH-1:0]                mem_dob
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

   arb_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]       wptr_q, wptr_d;
   logic [PTR_W-1:0]       rptr_q, rptr_d;
   logic [N_REQ-1:0]       rsp_valid_q, rsp_valid_d;

   logic                   clearing;
   logic                   run;
   logic [N_REQ-1:0]       wgnt_raw, rgnt_raw, wgnt, rgnt;
   logic [PTR_W-1:0]       widx, ridx;

   assign clearing = (state_q == ST_CLEAR);
   // No grants while reset is asserted, so nothing reaches the RAM or the
   // pointers in the cycle that is being reset.
   assign run      = (state_q == ST_RUN) && !reset;

   rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_wr_arb (
      .req   (req_valid & req_we),
      .ptr   (wptr_q),
      .grant (wgnt_raw)
   );

   rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rd_arb (
      .req   (req_valid & ~req_we),
      .ptr   (rptr_q),
      .grant (rgnt_raw)
   );

   assign wgnt      = run ? wgnt_raw : '0;
   assign rgnt      = run ? rgnt_raw : '0;
   assign req_ready = wgnt | rgnt;

   always_comb begin
      widx = '0;
      ridx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (wgnt[i]) widx = PTR_W'(i);
         if (rgnt[i]) ridx = PTR_W'(i);
      end
   end

   // RAM ports: the clear sequence owns the write port while in CLEAR.
   assign mem_ena   = clearing | (|wgnt);
   assign mem_wea   = mem_ena;
   assign mem_addra = clearing ? cnt_q : req_addr[widx];
   assign mem_dia   = clearing ? '0    : req_wdata[widx];
   assign mem_enb   = |rgnt;
   assign mem_addrb = req_addr[ridx];

   // A response registered just before reset is suppressed in the reset cycle.
   assign rsp_valid = rsp_valid_q & {N_REQ{~reset}};
   assign rsp_rdata = mem_dob;
   assign busy      = clearing | reset;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      rsp_valid_d = rgnt;
      if (clearing) begin
         // The counter parks on the last address; the RUN transition follows.
         if (cnt_q == LAST_ADDR) state_d = ST_RUN;
         else                    cnt_d   = cnt_q + 1'b1;
      end
      if (|wgnt) wptr_d = PTR_W'(rr_next(int'(widx), N_REQ));
      if (|rgnt) rptr_d = PTR_W'(rr_next(int'(ridx), N_REQ));
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q     <= ST_CLEAR;
         cnt_q       <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

endmodule

// File: tb/tb_bram_sdp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_sdp_arbiter
//   Bench for bram_sdp_arbiter with a behavioural SDP RAM (read-old on a
//   same-address collision). Inputs change 1 time unit after the rising edge,
//   outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bram_sdp_arbiter;

   localparam int NR = 4;
   localparam int AW = 9;
   localparam int DW = 32;
   localparam int SZ = 512;
   localparam int NV = 20;

   logic                   clk;
   logic                   reset;
   logic [NR-1:0]          req_valid;
   logic [NR-1:0]          req_we;
   logic [NR-1:0][AW-1:0]  req_addr;
   logic [NR-1:0][DW-1:0]  req_wdata;
   logic [NR-1:0]          req_ready;
   logic [NR-1:0]          rsp_valid;
   logic [DW-1:0]          rsp_rdata;
   logic                   busy;
   logic                   mem_ena, mem_wea, mem_enb;
   logic [AW-1:0]          mem_addra, mem_addrb;
   logic [DW-1:0]          mem_dia, mem_dob;

   bram_sdp_arbiter #(
      .N_REQ(NR), .SIZE(SZ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .busy      (busy),
      .mem_ena   (mem_ena),
      .mem_wea   (mem_wea),
      .mem_addra (mem_addra),
      .mem_dia   (mem_dia),
      .mem_enb   (mem_enb),
      .mem_addrb (mem_addrb),
      .mem_dob   (mem_dob)
   );

   // Behavioural RAM, pre-filled with a non-zero pattern so clearing shows.
   logic [DW-1:0] ram [SZ] = '{default: 32'hA5A5_A5A5};

   always @(posedge clk) begin
      if (mem_ena && mem_wea) ram[mem_addra] <= mem_dia;
      if (mem_enb)            mem_dob        <= ram[mem_addrb];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [NR-1:0]         valid;
      logic [NR-1:0]         we;
      logic [NR-1:0][AW-1:0] addr;
      logic [NR-1:0][DW-1:0] wdata;
      logic [NR-1:0]         exp_ready;
      logic                  exp_ena;
      logic [AW-1:0]         exp_addra;
      logic [DW-1:0]         exp_dia;
      logic                  exp_enb;
      logic [AW-1:0]         exp_addrb;
      logic [NR-1:0]         exp_rsp;
      logic [DW-1:0]         exp_rdata;
   } vec_t;

   vec_t vecs [NV];

   // Default addresses are 10+i, default write data is wbase+i.
   function automatic vec_t mk(logic [NR-1:0] v, logic [NR-1:0] we,
                               logic [DW-1:0] wbase, logic [NR-1:0] rdy,
                               logic ena, logic [AW-1:0] aa, logic [DW-1:0] da,
                               logic enb, logic [AW-1:0] ab,
                               logic [NR-1:0] rsp, logic [DW-1:0] rd);
      vec_t r;
      r.valid = v;
      r.we    = we;
      for (int i = 0; i < NR; i++) begin
         r.addr[i]  = AW'(10 + i);
         r.wdata[i] = wbase + DW'(i);
      end
      r.exp_ready = rdy;
      r.exp_ena   = ena;
      r.exp_addra = aa;
      r.exp_dia   = da;
      r.exp_enb   = enb;
      r.exp_addrb = ab;
      r.exp_rsp   = rsp;
      r.exp_rdata = rd;
      return r;
   endfunction

   // Watches one clear sequence: each busy cycle must write 0 to the next
   // address with reads blocked. Returns the number of busy cycles seen;
   // stop_at >= 0 returns early on the cycle writing that address.
   task automatic clear_phase(input string name, input int stop_at,
                              output int n);
      int bad;
      n   = 0;
      bad = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         if (!busy) break;
         if (req_ready !== '0 || rsp_valid !== '0 || mem_ena !== 1'b1 ||
             mem_wea !== 1'b1 || mem_enb !== 1'b0 ||
             mem_addra !== AW'(n) || mem_dia !== '0) bad++;
         n++;
         if (stop_at >= 0 && n > stop_at) break;
      end
      check({name, "_seq_bad"}, 64'(bad), 64'd0);
   endtask

   initial begin
      int n;
      int nz;

      reset     = 1'b1;
      req_valid = 4'b1111;
      req_we    = 4'b0000;
      req_addr  = '0;
      req_wdata = '0;

      vecs[0]  = mk(4'b1111, 4'b1111, 32'h100, 4'b0001, 1, 10, 32'h100, 0, 0,  4'b0000, 0);
      vecs[1]  = mk(4'b1111, 4'b1111, 32'h100, 4'b0010, 1, 11, 32'h101, 0, 0,  4'b0000, 0);
      vecs[2]  = mk(4'b1111, 4'b1111, 32'h100, 4'b0100, 1, 12, 32'h102, 0, 0,  4'b0000, 0);
      vecs[3]  = mk(4'b1111, 4'b1111, 32'h100, 4'b1000, 1, 13, 32'h103, 0, 0,  4'b0000, 0);
      vecs[4]  = mk(4'b1111, 4'b0000, 32'h100, 4'b0001, 0, 0,  0,       1, 10, 4'b0000, 0);
      vecs[5]  = mk(4'b1111, 4'b0000, 32'h100, 4'b0010, 0, 0,  0,       1, 11, 4'b0001, 32'h100);
      vecs[6]  = mk(4'b1111, 4'b0000, 32'h100, 4'b0100, 0, 0,  0,       1, 12, 4'b0010, 32'h101);
      vecs[7]  = mk(4'b1111, 4'b0000, 32'h100, 4'b1000, 0, 0,  0,       1, 13, 4'b0100, 32'h102);
      vecs[8]  = mk(4'b1111, 4'b0000, 32'h100, 4'b0001, 0, 0,  0,       1, 10, 4'b1000, 32'h103);
      vecs[9]  = mk(4'b0000, 4'b0000, 32'h100, 4'b0000, 0, 0,  0,       0, 0,  4'b0001, 32'h100);
      vecs[10] = mk(4'b0000, 4'b0000, 32'h100, 4'b0000, 0, 0,  0,       0, 0,  4'b0000, 0);
      // Same-address write (req 1) and read (req 2): read sees old data.
      vecs[11] = mk(4'b0110, 4'b0010, 32'h100, 4'b0110, 1, 5, 32'hDEADBEEF, 1, 5, 4'b0000, 0);
      vecs[11].addr[1]  = 5;
      vecs[11].addr[2]  = 5;
      vecs[11].wdata[1] = 32'hDEADBEEF;
      vecs[12] = mk(4'b0100, 4'b0000, 32'h100, 4'b0100, 0, 0, 0, 1, 5, 4'b0100, 32'h0);
      vecs[12].addr[2]  = 5;
      vecs[13] = mk(4'b0000, 4'b0000, 32'h100, 4'b0000, 0, 0, 0, 0, 0, 4'b0100, 32'hDEADBEEF);
      // Requester 0 writes while requester 3 reads.
      vecs[14] = mk(4'b1001, 4'b0001, 32'h100, 4'b1001, 1, 20, 32'h12345678, 1, 13, 4'b0000, 0);
      vecs[14].addr[0]  = 20;
      vecs[14].wdata[0] = 32'h12345678;
      vecs[15] = mk(4'b0001, 4'b0000, 32'h100, 4'b0001, 0, 0, 0, 1, 20, 4'b1000, 32'h103);
      vecs[15].addr[0]  = 20;
      vecs[16] = mk(4'b0000, 4'b0000, 32'h100, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, 32'h12345678);
      // Mixed traffic with both pointers away from zero.
      vecs[17] = mk(4'b1111, 4'b0101, 32'h200, 4'b0110, 1, 12, 32'h202, 1, 11, 4'b0000, 0);
      vecs[18] = mk(4'b1111, 4'b0101, 32'h200, 4'b1001, 1, 10, 32'h200, 1, 13, 4'b0010, 32'h101);
      vecs[19] = mk(4'b0000, 4'b0000, 32'h200, 4'b0000, 0, 0, 0, 0, 0, 4'b1000, 32'h103);

      // Reset state with all requesters asking.
      @(negedge clk);
      check("rst_busy",      64'(busy),      64'd1);
      check("rst_ready",     64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_enb",       64'(mem_enb),   64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Full clear: 512 busy cycles, addresses 0..511 zeroed.
      clear_phase("clear0", -1, n);
      check("clear0_len", 64'(n), 64'd512);
      check("clear0_busy_low", 64'(busy), 64'd0);
      req_valid = '0;
      nz = 0;
      for (int a = 0; a < SZ; a++) if (ram[a] !== '0) nz++;
      check("ram_cleared_nonzero", 64'(nz), 64'd0);

      // Table-driven RUN vectors.
      for (int k = 0; k < NV; k++) begin
         @(posedge clk); #1;
         req_valid = vecs[k].valid;
         req_we    = vecs[k].we;
         req_addr  = vecs[k].addr;
         req_wdata = vecs[k].wdata;
         @(negedge clk);
         check($sformatf("v%0d_ready", k), 64'(req_ready), 64'(vecs[k].exp_ready));
         check($sformatf("v%0d_ena", k),   64'(mem_ena),   64'(vecs[k].exp_ena));
         check($sformatf("v%0d_wea", k),   64'(mem_wea),   64'(vecs[k].exp_ena));
         check($sformatf("v%0d_enb", k),   64'(mem_enb),   64'(vecs[k].exp_enb));
         check($sformatf("v%0d_rsp", k),   64'(rsp_valid), 64'(vecs[k].exp_rsp));
         check($sformatf("v%0d_busy", k),  64'(busy),      64'd0);
         if (vecs[k].exp_ena) begin
            check($sformatf("v%0d_addra", k), 64'(mem_addra), 64'(vecs[k].exp_addra));
            check($sformatf("v%0d_dia", k),   64'(mem_dia),   64'(vecs[k].exp_dia));
         end
         if (vecs[k].exp_enb)
            check($sformatf("v%0d_addrb", k), 64'(mem_addrb), 64'(vecs[k].exp_addrb));
         if (vecs[k].exp_rsp != '0)
            check($sformatf("v%0d_rdata", k), 64'(rsp_rdata), 64'(vecs[k].exp_rdata));
      end

      // Reset on the cycle after a read grant: the response never shows.
      @(posedge clk); #1;
      req_valid = 4'b0001;
      req_we    = 4'b0000;
      req_addr  = '0;
      req_addr[0] = 10;
      @(negedge clk);
      check("rstrd_grant", 64'(req_ready), 64'b0001);
      @(posedge clk); #1;
      reset     = 1'b1;
      req_valid = 4'b1111;
      @(negedge clk);
      check("rstrd_rsp_in_reset", 64'(rsp_valid), 64'd0);
      check("rstrd_busy",         64'(busy),      64'd1);
      check("rstrd_ready",        64'(req_ready), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Reset at clear counter 200: the clear restarts from address 0.
      clear_phase("clear1", 200, n);
      check("clear1_partial_len", 64'(n), 64'd201);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      clear_phase("clear2", -1, n);
      check("clear2_len", 64'(n), 64'd512);
      check("clear2_busy_low", 64'(busy), 64'd0);
      req_valid = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
